// File: rtl/tow_pkg.sv
// tow_pkg: shared encodings for the tug-of-war arbiter and master controller
package tow_pkg;
  localparam logic [1:0] ARM_WAIT = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] HOLD     = 2'd2;
  localparam logic [1:0] OVER     = 2'd3;
  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;
  localparam logic [1:0] MC_CLEAR = 2'd0;
  localparam logic [1:0] MC_DARK  = 2'd1;
  localparam logic [1:0] MC_PLAY  = 2'd2;
  localparam logic [1:0] MC_SHOW  = 2'd3;
  typedef enum logic [1:0] {LED_NONE, LED_ALLON, LED_SCORE, LED_RESETLED} led_mode_t;
  function automatic logic mc_is_play(input logic [1:0] mc_state);
    return mc_state == MC_PLAY;
  endfunction
endpackage

// File: rtl/tow_rise_det.sv
// tow_rise_det: one-bit rising-edge detector with a registered history bit
module tow_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;
  assign rise = d & ~d_q;
  // history bit follows the input every cycle regardless of arbiter state
  always_ff @(posedge clk) begin
    if (rst) d_q <= 1'b0;
    else d_q <= d;
  end
endmodule

// File: rtl/tow_press_arbiter.sv
// tow_press_arbiter: decides each round winner and keeps rope position and match result
module tow_press_arbiter
  import tow_pkg::*;
#(
  parameter int POS_W   = 4,
  parameter int POS_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pa,
  input  logic             pb,
  input  logic             play,
  input  logic             clear,
  output logic             winrnd,
  output logic             winner,
  output logic             foul,
  output logic [POS_W-1:0] position,
  output logic             game_over,
  output logic             champion
);
  localparam logic [POS_W-1:0] POS_TOP   = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_START = POS_W'(POS_MAX / 2);
  logic ra, rb;
  logic [1:0] state_q, state_d;
  logic prio_q, prio_d, winrnd_q, winrnd_d, winner_q, winner_d, foul_q, foul_d;
  logic game_over_q, game_over_d, champion_q, champion_d;
  logic [POS_W-1:0] position_q, position_d, pos_next;
  logic decide, win, end_m;
  tow_rise_det u_rise_a (.clk(clk), .rst(rst), .d(pa), .rise(ra));
  tow_rise_det u_rise_b (.clk(clk), .rst(rst), .d(pb), .rise(rb));
  // a foul hands the round to the opponent; a double foul decides nothing
  always_comb begin
    decide      = state_q == ARMED && !clear && (play ? (ra | rb) : (ra ^ rb));
    win         = play ? ((ra & rb) ? prio_q : rb) : ra;
    pos_next    = win ? position_q - POS_W'(1) : position_q + POS_W'(1);
    end_m       = decide && (pos_next == POS_TOP || pos_next == '0);
    winrnd_d    = decide;
    winner_d    = decide ? win : winner_q;
    foul_d      = decide ? !play : foul_q;
    position_d  = decide ? pos_next : position_q;
    prio_d      = (decide && play && ra && rb) ? ~prio_q : prio_q;
    game_over_d = game_over_q | end_m;
    champion_d  = end_m ? win : champion_q;
    state_d     = state_q == ARM_WAIT ? (clear ? ARM_WAIT : ARMED)
                : state_q == ARMED    ? (end_m ? OVER : decide ? HOLD : clear ? ARM_WAIT : ARMED)
                : state_q == HOLD     ? (clear ? ARM_WAIT : HOLD)
                : OVER;
  end
  // register round result, score and FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARM_WAIT;
      prio_q      <= PLAYER_A;
      winrnd_q    <= 1'b0;
      winner_q    <= PLAYER_A;
      foul_q      <= 1'b0;
      position_q  <= POS_START;
      game_over_q <= 1'b0;
      champion_q  <= PLAYER_A;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      winrnd_q    <= winrnd_d;
      winner_q    <= winner_d;
      foul_q      <= foul_d;
      position_q  <= position_d;
      game_over_q <= game_over_d;
      champion_q  <= champion_d;
    end
  end
  assign winrnd    = winrnd_q;
  assign winner    = winner_q;
  assign foul      = foul_q;
  assign position  = position_q;
  assign game_over = game_over_q;
  assign champion  = champion_q;
endmodule

// File: tb/tb_tow_press_arbiter.sv
// tb_tow_press_arbiter: directed scenario checks for the round arbiter
module tb_tow_press_arbiter;
  logic clk = 1'b0, rst = 1'b0, pa = 1'b0, pb = 1'b0, play = 1'b0, clear = 1'b1;
  logic winrnd, winner, foul, game_over, champion;
  logic [3:0] position;
  int passed = 0, total = 0;

  tow_press_arbiter #(.POS_W(4), .POS_MAX(8)) dut (
    .clk(clk), .rst(rst), .pa(pa), .pb(pb), .play(play), .clear(clear),
    .winrnd(winrnd), .winner(winner), .foul(foul), .position(position),
    .game_over(game_over), .champion(champion)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pa = 1'b0; pb = 1'b0; play = 1'b0; clear = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic rearm();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({winrnd, winner, foul, position, game_over, champion} !== {3'b000, 4'd4, 2'b00}) begin
      $display("FAIL reset_values: got w%b n%b f%b p%0d g%b c%b, want 0 0 0 4 0 0",
               winrnd, winner, foul, position, game_over, champion);
    end else passed++;
  endtask

  task automatic test_valid_a();
    do_reset();
    play = 1'b1; clear = 1'b0;
    step();
    pa = 1'b1;
    step();
    total++;
    if ({winrnd, winner, foul, position} !== {3'b100, 4'd5})
      $display("FAIL valid_a: got w%b n%b f%b p%0d, want 1 0 0 5", winrnd, winner, foul, position);
    else passed++;
    step();
    total++;
    if (winrnd !== 1'b0) $display("FAIL valid_a_pulse_width: got %b want 0", winrnd);
    else passed++;
    pa = 1'b0; step();
    pb = 1'b1; step();
    total++;
    if (winrnd !== 1'b0 || position !== 4'd5)
      $display("FAIL hold_ignores_pb: got w%b p%0d want 0 5", winrnd, position);
    else passed++;
    pb = 1'b0; step();
    pa = 1'b1; step();
    total++;
    if (winrnd !== 1'b0) $display("FAIL hold_ignores_pa: got %b want 0", winrnd);
    else passed++;
    pa = 1'b0;
    rearm();
    pa = 1'b1; step();
    total++;
    if ({winrnd, winner, position} !== {2'b10, 4'd6})
      $display("FAIL valid_a_after_rearm: got w%b n%b p%0d want 1 0 6", winrnd, winner, position);
    else passed++;
    pa = 1'b0;
  endtask

  task automatic test_foul_b();
    do_reset();
    play = 1'b0; clear = 1'b0;
    step();
    pb = 1'b1; step();
    total++;
    if ({winrnd, winner, foul, position} !== {3'b101, 4'd5})
      $display("FAIL foul_b: got w%b n%b f%b p%0d, want 1 0 1 5", winrnd, winner, foul, position);
    else passed++;
    pb = 1'b0; step();
    total++;
    if ({winrnd, foul} !== 2'b01) $display("FAIL foul_held: got w%b f%b want 0 1", winrnd, foul);
    else passed++;
    pa = 1'b0; rearm();
    pa = 1'b1; step();
    total++;
    if ({winrnd, winner, foul, position} !== {3'b111, 4'd4})
      $display("FAIL foul_a: got w%b n%b f%b p%0d, want 1 1 1 4", winrnd, winner, foul, position);
    else passed++;
    pa = 1'b0;
  endtask

  task automatic test_tie();
    logic [2:0] exp_w;
    logic [11:0] exp_p;
    exp_w = 3'b010;
    exp_p = {4'd5, 4'd4, 4'd5};
    do_reset();
    play = 1'b1; clear = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      pa = 1'b1; pb = 1'b1; step();
      total++;
      if ({winrnd, winner, foul, position} !== {1'b1, exp_w[i], 1'b0, exp_p[4*i +: 4]})
        $display("FAIL tie_%0d: got w%b n%b f%b p%0d, want 1 %b 0 %0d",
                 i, winrnd, winner, foul, position, exp_w[i], exp_p[4*i +: 4]);
      else passed++;
      pa = 1'b0; pb = 1'b0; step();
      rearm();
    end
  endtask

  task automatic test_double_foul();
    do_reset();
    play = 1'b0; clear = 1'b0;
    step();
    pa = 1'b1; pb = 1'b1; step();
    total++;
    if (winrnd !== 1'b0 || position !== 4'd4)
      $display("FAIL double_foul: got w%b p%0d want 0 4", winrnd, position);
    else passed++;
    step();
    pa = 1'b0; pb = 1'b0; step();
    play = 1'b1; pa = 1'b1; step();
    total++;
    if ({winrnd, winner, foul, position} !== {3'b100, 4'd5})
      $display("FAIL after_double_foul: got w%b n%b f%b p%0d want 1 0 0 5", winrnd, winner, foul, position);
    else passed++;
    pa = 1'b0;
  endtask

  task automatic test_match_end(input logic who);
    logic [3:0] exp_p;
    do_reset();
    play = 1'b1; clear = 1'b0;
    step();
    exp_p = 4'd4;
    for (int i = 0; i < 4; i++) begin
      exp_p = who ? exp_p - 4'd1 : exp_p + 4'd1;
      pa = ~who; pb = who; step();
      total++;
      if ({winrnd, winner, position, game_over, champion} !== {1'b1, who, exp_p, (i == 3), (i == 3) & who})
        $display("FAIL match_%b_round_%0d: got w%b n%b p%0d g%b c%b want 1 %b %0d %b %b",
                 who, i, winrnd, winner, position, game_over, champion, who, exp_p, i == 3, (i == 3) & who);
      else passed++;
      pa = 1'b0; pb = 1'b0; step();
      rearm();
    end
    pa = 1'b1; step();
    pa = 1'b0; step();
    pb = 1'b1; step();
    total++;
    if ({winrnd, position, game_over, champion} !== {1'b0, exp_p, 1'b1, who})
      $display("FAIL over_terminal_%b: got w%b p%0d g%b c%b want 0 %0d 1 %b",
               who, winrnd, position, game_over, champion, exp_p, who);
    else passed++;
    pb = 1'b0;
    do_reset();
    total++;
    if ({position, game_over, champion} !== {4'd4, 2'b00})
      $display("FAIL reset_from_over_%b: got p%0d g%b c%b want 4 0 0", who, position, game_over, champion);
    else passed++;
  endtask

  task automatic test_held_button();
    do_reset();
    play = 1'b1; pa = 1'b1;
    step();
    clear = 1'b0; step();
    step();
    total++;
    if (winrnd !== 1'b0 || position !== 4'd4)
      $display("FAIL held_button: got w%b p%0d want 0 4", winrnd, position);
    else passed++;
    pa = 1'b0; step();
    pa = 1'b1; step();
    total++;
    if ({winrnd, position} !== {1'b1, 4'd5})
      $display("FAIL press_after_release: got w%b p%0d want 1 5", winrnd, position);
    else passed++;
    pa = 1'b0;
  endtask

  task automatic test_reset_mid_round();
    do_reset();
    play = 1'b1; clear = 1'b0;
    step();
    pa = 1'b1; rst = 1'b1; step();
    rst = 1'b0;
    total++;
    if ({winrnd, winner, foul, position, game_over, champion} !== {3'b000, 4'd4, 2'b00})
      $display("FAIL reset_mid_round: got w%b n%b f%b p%0d g%b c%b want 0 0 0 4 0 0",
               winrnd, winner, foul, position, game_over, champion);
    else passed++;
    step();
    step();
    total++;
    if (winrnd !== 1'b0) $display("FAIL edge_lost_in_arming: got %b want 0", winrnd);
    else passed++;
    pa = 1'b0;
  endtask

  initial begin
    test_reset();
    test_valid_a();
    test_foul_b();
    test_tie();
    test_double_foul();
    test_match_end(1'b0);
    test_match_end(1'b1);
    test_held_button();
    test_reset_mid_round();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tow_press_arbiter.md
# tow_press_arbiter

Player-input arbiter and round scorer for the tug-of-war game. Takes the two synchronized player buttons, decides who won each round (valid press during PLAY, or opponent's foul press while DARK), pulses `winrnd` to the master controller, and maintains the rope position and match result. Sits between the button synchronizers and the master controller. `position` drives the score LED display.

## Interface
- `POS_W`, 4: width of the rope-position register.
- `POS_MAX`, 8: position at which player A wins the match. Player B wins at 0. Start is `POS_MAX/2`. Must satisfy 2 ≤ `POS_MAX` < 2^`POS_W`.
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `pa`  in  1  player A button, already synchronized and debounced, level.
- `pb`  in  1  player B button, same treatment as `pa`.
- `play`  in  1  high while the master controller is in PLAY (LEDs lit, presses valid).
- `clear`  in  1  master controller clear. Low only in DARK/PLAY; arbitration is enabled only while low.
- `winrnd`  out  1  one-cycle pulse: round decided.
- `winner`  out  1  round winner, 0=A, 1=B. Valid with `winrnd`, held until next `winrnd`.
- `foul`  out  1  high with `winrnd` when the round was decided by a foul. Held like `winner`.
- `position`  out  `POS_W`  rope position.
- `game_over`  out  1  match finished. Sticky until `rst`.
- `champion`  out  1  match winner, 0=A, 1=B. Valid while `game_over` is high.

## Operation
- **Press detection:** rising edges only: `pa & ~pa_q`. The `pa_q`/`pb_q` history registers update every cycle in every state. A button held across arming never counts.
- **States:**
  - ARM_WAIT: stay until `clear`=0, then go to ARMED.
  - ARMED: arbitrate edges. On a decision, go to HOLD.
  - HOLD: ignore all presses. Wait for `clear`=1, then go to ARM_WAIT.
  - OVER: terminal. No further rounds.
  - Reset state is ARM_WAIT.
- **Round decision in ARMED with `play`=1:**
  - Single edge: that player wins, `foul`=0.
  - Both edges in the same cycle: the player named by the `prio` register wins, then `prio` toggles.
- **Round decision in ARMED with `play`=0 (foul):**
  - Single edge: the opponent wins, `foul`=1.
  - Both edges in the same cycle: double foul. Ignored, no `winrnd`, stay in ARMED.
- **Scoring:** A win increments `position`; B win decrements it. Saturation is never reached, because the match ends first.
- **Match end:** on the same edge that `position` becomes `POS_MAX` or 0:
  - `game_over` is set.
  - `champion` is set to the winner.
  - the FSM goes to OVER.
  - `winrnd` still pulses for that final round.
- **ARMED exit on `clear`:** if `clear` rises while in ARMED with no edge, go to ARM_WAIT.
- **Reset values:**
  - `winrnd`=0, `winner`=0, `foul`=0.
  - `position`=`POS_MAX/2`.
  - `game_over`=0, `champion`=0.
  - `prio`=0 (A), history registers =0, state ARM_WAIT.
- **Reset priority:** `rst` overrides every other input on the same edge, including mid-round and in OVER.

## Timing
- **Latency:** if `pa` is first sampled high at edge k (with `pa_q`=0), then `winrnd`, `winner`, `foul` and the updated `position` are registered at edge k. They are visible in the cycle after k.
- **Pulse width:** `winrnd` is exactly 1 cycle wide. The FSM is in HOLD from edge k on.
- **Round spacing:** the master controller's `clear` lags `winrnd` by at least one cycle. HOLD guarantees no second `winrnd` until `clear` has been seen high and then low again. Minimum spacing is 3 cycles.
- **Arming:** `clear` falling at edge j allows a press decision at edge j+1 at the earliest (transition through ARM_WAIT to ARMED).
- **Edge lost in transit:** an edge coinciding with the ARM_WAIT→ARMED transition is lost. This is acceptable: the button was pressed before arming.
- **`play` timing:** `play` is sampled on the same edge as the press edge. No extra synchronization is applied.

## Structure
- **Shared package `tow_pkg`:**
  - FSM encodings ARM_WAIT/ARMED/HOLD/OVER.
  - Player ids PLAYER_A=0, PLAYER_B=1.
  - Master controller state and LED-mode constants (NONE/ALLON/SCORE/RESETLED), so `play` decoding and this block share one definition.
- **Sub-module `tow_rise_det`:** one-bit registered rising-edge detector. Ports `clk`, `rst`, `d`, `rise`. Instantiated once per player.
- **Top:** FSM, arbitration/priority logic and score registers stay in the top module.

## Test plan
- **Valid A press:** reset, `clear`=0, `play`=1, `pa` 0→1 → one `winrnd` pulse, `winner`=0, `foul`=0, `position` 4→5. State goes to HOLD; further `pa`/`pb` toggles give no pulse until `clear` goes 1 then 0.
- **Foul by B:** `clear`=0, `play`=0, `pb` rises → `winrnd`, `winner`=0, `foul`=1, `position` 4→5.
- **Tie:** two ties in PLAY, each with simultaneous `pa`/`pb` rises, re-arming in between → first to A (`position` 5), second to B (`position` 4). `prio` alternates.
- **Double foul:** simultaneous rises with `play`=0 → no `winrnd`. A later single `pa` rise with `play`=1 still wins normally.
- **Match end:** four A wins from reset → `position`=8, `game_over`=1, `champion`=0 on the fourth `winrnd`. Further presses and re-arms produce nothing. `rst` restores `position`=4 and `game_over`=0.
- **Held button and reset mid-round:**
  - `pa` held high through arming → no win.
  - `rst` asserted on the same edge as a press edge → no `winrnd`, all reset values.
